// File: rtl/mem_refill_arb.sv
// Shares the single external memory port between I-cache refills and D-cache refills/stores.
// It runs each transaction on the port and pulses arrival to release the pipeline miss stalls.
module mem_refill_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        fill_data,
  output logic [$clog2(BEATS)-1:0] fill_idx,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_arrival,
  output logic                     d_arrival
);

  localparam int unsigned IDX_W    = $clog2(BEATS);
  localparam int unsigned LINE_OFF = $clog2(BEATS * DATA_W / 8);
  localparam int unsigned WORD_OFF = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_e;
  typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_e;

  state_e              state_q, state_d;
  side_e               owner_q, owner_d;
  side_e               last_q, last_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                i_arr_q, i_arr_d;
  logic                d_arr_q, d_arr_d;
  logic                beat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= SIDE_I;
      last_q    <= SIDE_I;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      i_arr_q   <= 1'b0;
      d_arr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      i_arr_q   <= i_arr_d;
      d_arr_q   <= d_arr_d;
    end
  end

  // Arbitration, command latching and beat sequencing.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beat    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) begin
            owner_d = (last_q == SIDE_I) ? SIDE_D : SIDE_I;
          end else begin
            owner_d = d_req ? SIDE_D : SIDE_I;
          end
          last_d  = owner_d;
          state_d = CMD;
          if (owner_d == SIDE_I) begin
            we_d    = 1'b0;
            addr_d  = {i_addr[ADDR_W-1:LINE_OFF], LINE_OFF'(0)};
            wdata_d = '0;
          end else begin
            we_d    = d_we;
            addr_d  = d_we ? {d_addr[ADDR_W-1:WORD_OFF], WORD_OFF'(0)}
                           : {d_addr[ADDR_W-1:LINE_OFF], LINE_OFF'(0)};
            wdata_d = d_wdata;
          end
        end
      end
      CMD: begin
        if (mem_gnt) begin
          state_d = we_q ? DONE : DATA;
        end
      end
      DATA: begin
        if (mem_rvalid) begin
          beat = 1'b1;
          if (cnt_q == IDX_W'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_req_d = (state_d == CMD);
    mem_we_d  = (state_d == CMD) && we_d;
    i_arr_d   = (state_d == DONE) && (owner_d == SIDE_I);
    d_arr_d   = (state_d == DONE) && (owner_d == SIDE_D);
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_arrival = i_arr_q;
  assign d_arrival = d_arr_q;

  // Fill beats are forwarded in the cycle they arrive; gated so stray rvalid never writes.
  assign fill_data = beat ? mem_rdata : '0;
  assign fill_idx  = cnt_q;
  assign i_fill_we = beat && (owner_q == SIDE_I);
  assign d_fill_we = beat && (owner_q == SIDE_D);

endmodule
